sdram_frame_pingpong_ctrl: RTL

//  Ping-pong frame-buffer scheduler for the 2-FIFO SDRAM controller. Owns the two frame regions
//  (BUF0 = L-Bank1/2, BUF1 = L-Bank3/4); drives wr_load/wr_addr/wr_max_addr and rd_load/rd_addr/
//  rd_max_addr so the writer never overwrites the buffer being read (no tearing).

---
 rtl/sdram_fb_pkg.sv | 23 ++
 rtl/sdram_frame_pingpong_ctrl_if.sv | 37 +++
 rtl/sdram_load_pulse.sv | 35 +++
 rtl/sdram_frame_pingpong_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_fb_pkg.sv
// Shared widths, default buffer layout and FSM state type for the SDRAM
// frame ping-pong scheduler.
package sdram_fb_pkg;

   localparam int unsigned ADDR_W     = 22;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned LOAD_CNT_W = 4;

   localparam logic [ADDR_W-1:0] DEF_BUF0_BASE   = 22'h000000;
   localparam logic [ADDR_W-1:0] DEF_BUF1_BASE   = 22'h200000;
   localparam logic [ADDR_W-1:0] DEF_FRAME_WORDS = 22'd307200;
   localparam int unsigned       DEF_LOAD_CYCLES = 4;

   typedef enum logic {
      WAIT_INIT = 1'b0,
      RUN       = 1'b1
   } fsm_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sdram_frame_pingpong_ctrl_if.sv
// Frame-event inputs and buffer-region outputs between the ping-pong
// scheduler (master) and the FIFO wrapper / video timing side (slave).
interface sdram_frame_pingpong_ctrl_if;
   import sdram_fb_pkg::*;

   logic              sdram_init_done;
   logic              wr_frame_start;
   logic              rd_frame_start;
   logic              frame_write_done;
   logic              frame_read_done;
   logic              wr_load;
   logic              rd_load;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] wr_max_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] rd_max_addr;
   logic              wr_buf;
   logic              rd_buf;
   logic              rd_valid;
   logic [CNT_W-1:0]  drop_cnt;
   logic [CNT_W-1:0]  repeat_cnt;

   modport master (
      input  sdram_init_done, wr_frame_start, rd_frame_start,
             frame_write_done, frame_read_done,
      output wr_load, rd_load, wr_addr, wr_max_addr, rd_addr, rd_max_addr,
             wr_buf, rd_buf, rd_valid, drop_cnt, repeat_cnt
   );

   modport slave (
      output sdram_init_done, wr_frame_start, rd_frame_start,
             frame_write_done, frame_read_done,
      input  wr_load, rd_load, wr_addr, wr_max_addr, rd_addr, rd_max_addr,
             wr_buf, rd_buf, rd_valid, drop_cnt, repeat_cnt
   );

endinterface

// File: rtl/sdram_load_pulse.sv
// Restartable fixed-length pulse: rises the cycle after start_i and stays
// high for LOAD_CYCLES cycles; a new start reloads the count.
module sdram_load_pulse
   import sdram_fb_pkg::*;
#(
   parameter int unsigned LOAD_CYCLES = DEF_LOAD_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   output logic pulse_o
);

   logic [LOAD_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = LOAD_CNT_W'(LOAD_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/sdram_frame_pingpong_ctrl.sv
// Ping-pong frame-buffer scheduler: picks write/read buffers so the writer
// never touches the frame being read and the reader takes the newest frame.
module sdram_frame_pingpong_ctrl
   import sdram_fb_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BUF0_BASE   = DEF_BUF0_BASE,
   parameter logic [ADDR_W-1:0] BUF1_BASE   = DEF_BUF1_BASE,
   parameter logic [ADDR_W-1:0] FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int unsigned       LOAD_CYCLES = DEF_LOAD_CYCLES
) (
   input logic                         clk,
   input logic                         rst,
   sdram_frame_pingpong_ctrl_if.master fb
);

   fsm_state_e state_q, state_d;
   logic       active, flush;

   logic [1:0]        valid_q, valid_d;
   logic [1:0]        unread_q, unread_d;
   logic              latest_q, latest_d;
   logic              rd_buf_q, rd_buf_d;
   logic              wr_buf_q, wr_buf_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_busy_q, rd_busy_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  repeat_q, repeat_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_max_q, wr_max_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_max_q, rd_max_d;
   logic              rd_go, wr_go, wr_target;

   function automatic logic [ADDR_W-1:0] base_of(input logic sel);
      return sel ? BUF1_BASE : BUF0_BASE;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_INIT: if (fb.sdram_init_done)  state_d = RUN;
         RUN:       if (!fb.sdram_init_done) state_d = WAIT_INIT;
         default:   state_d = WAIT_INIT;
      endcase
   end

   always_comb begin
      active = (state_q == RUN) && fb.sdram_init_done;
      flush  = (state_q == RUN) && !fb.sdram_init_done;
   end

   // Events resolve in order: read done, read select (pre-done flags),
   // write done, then write select against the post-select reader.
   always_comb begin
      valid_d    = valid_q;
      unread_d   = unread_q;
      latest_d   = latest_q;
      rd_buf_d   = rd_buf_q;
      wr_buf_d   = wr_buf_q;
      rd_valid_d = rd_valid_q;
      rd_busy_d  = rd_busy_q;
      drop_d     = drop_q;
      repeat_d   = repeat_q;
      rd_go      = 1'b0;
      wr_go      = 1'b0;
      wr_target  = 1'b0;

      if (fb.frame_read_done) rd_busy_d = 1'b0;

      if (flush) begin
         valid_d  = '0;
         unread_d = '0;
      end else if (active) begin
         if (fb.rd_frame_start) begin
            rd_go     = 1'b1;
            rd_busy_d = 1'b1;
            if (valid_q[latest_q] && unread_q[latest_q]) begin
               rd_buf_d           = latest_q;
               unread_d[latest_q] = 1'b0;
               rd_valid_d         = 1'b1;
            end else if (valid_q[rd_buf_q]) begin
               repeat_d   = sat_inc(repeat_q);
               rd_valid_d = 1'b1;
            end else begin
               rd_valid_d = 1'b0;
            end
         end

         if (fb.frame_write_done) begin
            valid_d[wr_buf_q]  = 1'b1;
            unread_d[wr_buf_q] = 1'b1;
            latest_d           = wr_buf_q;
         end

         if (fb.wr_frame_start) begin
            wr_go     = 1'b1;
            wr_target = rd_busy_d ? ~rd_buf_d : ~latest_d;
            if (unread_d[wr_target]) drop_d = sat_inc(drop_q);
            valid_d[wr_target]  = 1'b0;
            unread_d[wr_target] = 1'b0;
            wr_buf_d            = wr_target;
         end
      end
   end

   always_comb begin
      wr_addr_d = wr_addr_q;
      wr_max_d  = wr_max_q;
      rd_addr_d = rd_addr_q;
      rd_max_d  = rd_max_q;
      if (wr_go) begin
         wr_addr_d = base_of(wr_buf_d);
         wr_max_d  = base_of(wr_buf_d) + FRAME_WORDS;
      end
      if (rd_go) begin
         rd_addr_d = base_of(rd_buf_d);
         rd_max_d  = base_of(rd_buf_d) + FRAME_WORDS;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         unread_q   <= '0;
         latest_q   <= 1'b0;
         rd_buf_q   <= 1'b1;
         wr_buf_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_busy_q  <= 1'b0;
         drop_q     <= '0;
         repeat_q   <= '0;
         wr_addr_q  <= BUF0_BASE;
         wr_max_q   <= BUF0_BASE + FRAME_WORDS;
         rd_addr_q  <= BUF0_BASE;
         rd_max_q   <= BUF0_BASE + FRAME_WORDS;
      end else begin
         valid_q    <= valid_d;
         unread_q   <= unread_d;
         latest_q   <= latest_d;
         rd_buf_q   <= rd_buf_d;
         wr_buf_q   <= wr_buf_d;
         rd_valid_q <= rd_valid_d;
         rd_busy_q  <= rd_busy_d;
         drop_q     <= drop_d;
         repeat_q   <= repeat_d;
         wr_addr_q  <= wr_addr_d;
         wr_max_q   <= wr_max_d;
         rd_addr_q  <= rd_addr_d;
         rd_max_q   <= rd_max_d;
      end
   end

   sdram_load_pulse #(.LOAD_CYCLES(LOAD_CYCLES)) u_wr_load (
      .clk    (clk),
      .rst    (rst),
      .start_i(wr_go),
      .pulse_o(fb.wr_load)
   );

   sdram_load_pulse #(.LOAD_CYCLES(LOAD_CYCLES)) u_rd_load (
      .clk    (clk),
      .rst    (rst),
      .start_i(rd_go),
      .pulse_o(fb.rd_load)
   );

   assign fb.wr_addr     = wr_addr_q;
   assign fb.wr_max_addr = wr_max_q;
   assign fb.rd_addr     = rd_addr_q;
   assign fb.rd_max_addr = rd_max_q;
   assign fb.wr_buf      = wr_buf_q;
   assign fb.rd_buf      = rd_buf_q;
   assign fb.rd_valid    = rd_valid_q;
   assign fb.drop_cnt    = drop_q;
   assign fb.repeat_cnt  = repeat_q;

endmodule
